ysyx_23060061_regfile_sb: RTL and testbench

- Parametrised integer register file: one write port, NR_READ combinational read ports, per-register scoreboard (busy bits) for a pipelined core.
- Decode marks a destination busy at issue; writeback clears it while writing data.
- Read ports return data plus a busy flag, so hazard logic stalls on RAW dependencies.
- Drop-in successor to the single-cycle GPR array.

---
 rtl/ysyx_23060061_regfile_sb.sv | 116 +++++++++++
 tb/tb_ysyx_23060061_regfile_sb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_regfile_sb
// Description : Integer register file with one write port, NR_READ
//               combinational read ports and a per-register busy scoreboard.
//               Optional write-through bypass: YSYX_23060061_REGFILE_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060061_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic                          flush,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int c_DEPTH = 2**ADDR_WIDTH;
  localparam int c_CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]    r_busy;
  logic [c_CW-1:0]       r_busy_cnt;

  logic                  w_wr;
  logic                  w_set;
  logic                  w_same;
  logic                  w_inc;
  logic                  w_dec;
  logic [c_DEPTH-1:0]    w_busy_next;
  logic [c_CW-1:0]       w_cnt_next;

  // Index 0 is hardwired: never written, never marked busy.
  assign w_wr   = wen && (waddr != '0);
  assign w_set  = issue_en && (issue_rd != '0);
  assign w_same = w_wr && w_set && (waddr == issue_rd);

  // Counter tracks the population of busy bits incrementally.
  assign w_inc  = w_set && !r_busy[issue_rd];
  assign w_dec  = w_wr && r_busy[waddr] && !w_same;

  always_comb begin
    w_busy_next = flush ? '0 : r_busy;
    if (w_wr && !flush) begin
      w_busy_next[waddr] = 1'b0;
    end
    // Applied last: a younger in-flight writer outranks writeback and flush.
    if (w_set) begin
      w_busy_next[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    if (flush) begin
      w_cnt_next = c_CW'(w_set);
    end else begin
      w_cnt_next = r_busy_cnt + c_CW'(w_inc) - c_CW'(w_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NR_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rb;

    assign w_ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_rd = (w_ra == '0) ? '0 : r_mem[w_ra];
      w_rb = (w_ra == '0) ? 1'b0 : r_busy[w_ra];
`ifdef YSYX_23060061_REGFILE_BYPASS_EN
      if (w_wr && (waddr == w_ra)) begin
        w_rd = wdata;
        w_rb = w_same;
      end
`endif
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rbusy[k]                          = w_rb;
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060061_regfile_sb
// Description : Directed table-driven bench for the scoreboarded regfile
//               (four read ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060061_regfile_sb;

  logic         clk;
  logic         rst;
  logic         wen;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         issue_en;
  logic [4:0]   issue_rd;
  logic         flush;
  logic [19:0]  raddr;
  logic [127:0] rdata;
  logic [3:0]   rbusy;
  logic [5:0]   busy_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic         wen;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         issue_en;
    logic [4:0]   issue_rd;
    logic         flush;
    logic [19:0]  raddr;
    logic [127:0] exp_rdata;
    logic [3:0]   exp_rbusy;
    logic [5:0]   exp_cnt;
  } vec_t;

  vec_t vecs[10];

  ysyx_23060061_regfile_sb #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .NR_READ   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .flush   (flush),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [127:0] pd(input logic [31:0] d0, input logic [31:0] d1,
                                      input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string nm, input logic [127:0] ed, input logic [3:0] eb,
                       input logic [5:0] ec);
    n_vec++;
    if (rdata !== ed || rbusy !== eb || busy_cnt !== ec) begin
      n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_cnt=%0d, want rdata=%h rbusy=%b busy_cnt=%0d",
               nm, rdata, rbusy, busy_cnt, ed, eb, ec);
    end
  endtask

  task automatic idle_ctrl();
    wen      = 1'b0;
    waddr    = '0;
    wdata    = '0;
    issue_en = 1'b0;
    issue_rd = '0;
    flush    = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    wen      = v.wen;
    waddr    = v.waddr;
    wdata    = v.wdata;
    issue_en = v.issue_en;
    issue_rd = v.issue_rd;
    flush    = v.flush;
    raddr    = v.raddr;
    @(posedge clk);
    #1;
    idle_ctrl();
    #1;
    check(nm, v.exp_rdata, v.exp_rbusy, v.exp_cnt);
  endtask

  task automatic check_all_zero(input string nm);
    for (int g = 0; g < 8; g++) begin
      raddr = pa(4*g, 4*g+1, 4*g+2, 4*g+3);
      #1;
      check($sformatf("%s_grp%0d", nm, g), '0, 4'b0000, 6'd0);
    end
  endtask

  initial begin
    //        wen   waddr  wdata          iss   rd     flush raddr          exp rdata                              rbusy    cnt
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, pa(0,0,0,0),   pd(0,0,0,0),                           4'b0000, 6'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, pa(5,0,0,0),   pd(0,0,0,0),                           4'b0001, 6'd1};
    vecs[2] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  1'b0, pa(5,0,0,0),   pd(32'h12345678,0,0,0),                4'b0000, 6'd0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, pa(7,5,0,0),   pd(0,32'h12345678,0,0),                4'b0001, 6'd1};
    vecs[4] = '{1'b1, 5'd7,  32'hA5,       1'b1, 5'd7,  1'b0, pa(7,5,0,0),   pd(32'hA5,32'h12345678,0,0),           4'b0001, 6'd1};
    vecs[5] = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  1'b0, pa(7,9,5,0),   pd(32'hA5,32'h99,32'h12345678,0),      4'b0001, 6'd1};
    vecs[6] = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd3,  1'b0, pa(7,3,9,0),   pd(32'h77,0,32'h99,0),                 4'b0010, 6'd1};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, pa(0,3,7,9),   pd(0,0,32'h77,32'h99),                 4'b0010, 6'd1};
    vecs[8] = '{1'b1, 5'd12, 32'h0C,       1'b1, 5'd12, 1'b0, pa(12,3,7,0),  pd(32'h0C,0,32'h77,0),                 4'b0011, 6'd2};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, pa(12,3,7,5),  pd(32'h0C,0,32'h77,32'h12345678),      4'b0000, 6'd0};

    rst = 1'b1;
    idle_ctrl();
    raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Fill the whole scoreboard one register per cycle.
    for (int r = 1; r < 32; r++) begin
      issue_en = 1'b1;
      issue_rd = 5'(r);
      @(posedge clk);
      #1;
    end
    idle_ctrl();
    raddr = pa(1, 16, 31, 0);
    #1;
    check("fill_31", '0, 4'b0111, 6'd31);

    apply('{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, pa(3,0,0,0), pd(0,0,0,0), 4'b0001, 6'd31},
          "reissue_x3");
    apply('{1'b1, 5'd10, 32'hAB, 1'b1, 5'd9, 1'b1, pa(9,3,10,31), pd(32'h99,0,32'hAB,0),
            4'b0001, 6'd1}, "flush_issue_write");

    // Same-cycle write/read of x4.
    wen   = 1'b1;
    waddr = 5'd4;
    wdata = 32'h55;
    raddr = pa(0, 4, 0, 0);
    #1;
`ifdef YSYX_23060061_REGFILE_BYPASS_EN
    check("rd_during_wr", pd(0,32'h55,0,0), 4'b0000, 6'd1);
`else
    check("rd_during_wr", pd(0,0,0,0), 4'b0000, 6'd1);
`endif
    @(posedge clk);
    #1;
    idle_ctrl();
    #1;
    check("rd_after_wr", pd(0,32'h55,0,0), 4'b0000, 6'd1);

    wen      = 1'b1;
    waddr    = 5'd4;
    wdata    = 32'h66;
    issue_en = 1'b1;
    issue_rd = 5'd4;
    #1;
`ifdef YSYX_23060061_REGFILE_BYPASS_EN
    check("rd_during_wr_issue", pd(0,32'h66,0,0), 4'b0010, 6'd1);
`else
    check("rd_during_wr_issue", pd(0,32'h55,0,0), 4'b0000, 6'd1);
`endif
    @(posedge clk);
    #1;
    idle_ctrl();
    #1;
    check("rd_after_wr_issue", pd(0,32'h66,0,0), 4'b0010, 6'd2);

    apply('{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, pa(2,0,0,0), pd(0,0,0,0), 4'b0001, 6'd3},
          "issue_x2");
    apply('{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, pa(2,6,4,9), pd(0,0,32'h66,32'h99),
            4'b1111, 6'd4}, "issue_x6");

    // Reset dominates a simultaneous write, issue and flush.
    rst      = 1'b1;
    wen      = 1'b1;
    waddr    = 5'd5;
    wdata    = 32'hFF;
    issue_en = 1'b1;
    issue_rd = 5'd8;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_ctrl();
    raddr = pa(2, 6, 5, 8);
    #1;
    check("mid_reset", '0, 4'b0000, 6'd0);
    check_all_zero("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
